instr_prefetch_buffer: RTL and testbench

Prefetch stage between the instruction-side OBI bus and the ID stage. It issues sequential OBI read requests, tracks outstanding transactions, and buffers returned instructions together with their PCs and bus-error flags in a small FIFO. Flushes redirect fetch to a new address and discard every response still in flight from the old stream. The block replaces the single-request fetch path, so the ID stage consumes a valid/ready instruction stream.

---
 rtl/instr_prefetch_buffer.sv | 151 +++++++++++++++
 tb/tb_instr_prefetch_buffer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_prefetch_buffer.sv
// Instruction prefetch buffer: issues sequential OBI reads under a credit limit
// and queues {pc, instr, err} for the ID stage; flushes redirect and drop old responses.
module instr_prefetch_buffer #(
  parameter int DEPTH           = 4,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [29:0] boot_addr_i,
  input  logic        flush_i,
  input  logic [31:0] flush_addr_i,
  output logic        obi_req_o,
  input  logic        obi_gnt_i,
  output logic [31:0] obi_addr_o,
  output logic        obi_we_o,
  output logic [3:0]  obi_be_o,
  output logic [31:0] obi_wdata_o,
  input  logic        obi_rvalid_i,
  output logic        obi_rready_o,
  input  logic [31:0] obi_rdata_i,
  input  logic        obi_err_i,
  output logic        valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic        err_o,
  input  logic        ready_i
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);

  logic [31:0]   req_addr_q, req_addr_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [31:0]   redirect_addr_q, redirect_addr_d;
  logic [OW-1:0] outstanding_q, outstanding_d;
  logic [OW-1:0] discard_q, discard_d;
  logic          pending_q, pending_d;
  logic          stale_req_q, stale_req_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic [31:0] instr_mem [DEPTH];
  logic [31:0] pc_mem    [DEPTH];
  logic        err_mem   [DEPTH];

  logic        credit_ok, gnt, drop_resp, push, pop;
  logic [31:0] flush_addr_w;

  assign flush_addr_w = flush_addr_i & ~32'h3;
  assign credit_ok    = (int'(outstanding_q) < MAX_OUTSTANDING) &&
                        (int'(count_q) + int'(outstanding_q) < DEPTH);

  // Gated by reset so the bus sees no request while the core is held in reset.
  assign obi_req_o    = rst_n_i & (pending_q | (!flush_i & credit_ok));
  assign obi_addr_o   = req_addr_q;
  assign obi_we_o     = 1'b0;
  assign obi_be_o     = 4'b1111;
  assign obi_wdata_o  = 32'h0;
  assign obi_rready_o = 1'b1;

  assign gnt       = obi_req_o & obi_gnt_i;
  assign drop_resp = (discard_q != '0);
  assign push      = obi_rvalid_i & !flush_i & !drop_resp;
  assign pop       = valid_o & ready_i & !flush_i;

  assign valid_o = (count_q != '0);
  assign instr_o = valid_o ? instr_mem[rd_ptr_q] : 32'h0;
  assign pc_o    = valid_o ? pc_mem[rd_ptr_q]    : 32'h0;
  assign err_o   = valid_o & err_mem[rd_ptr_q];

  always_comb begin
    // NOTE: every _d is defaulted to its _q first so no path leaves it unassigned (no latches).
    req_addr_d      = req_addr_q;
    resp_pc_d       = resp_pc_q;
    redirect_addr_d = redirect_addr_q;
    stale_req_d     = stale_req_q;
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    pending_d       = obi_req_o & !obi_gnt_i;
    outstanding_d   = outstanding_q + OW'(gnt) - OW'(obi_rvalid_i);
    discard_d       = discard_q + OW'(gnt & stale_req_q) - OW'(obi_rvalid_i & drop_resp);
    count_d         = count_q + CW'(push) - CW'(pop);

    if (gnt) begin
      req_addr_d  = stale_req_q ? redirect_addr_q : req_addr_q + 32'd4;
      stale_req_d = 1'b0;
    end
    if (push) begin
      resp_pc_d = resp_pc_q + 32'd4;
      wr_ptr_d  = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end

    // Everything in flight at the flush, including this cycle's grant, belongs to the old stream.
    if (flush_i) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
      resp_pc_d = flush_addr_w;
      discard_d = outstanding_q + OW'(gnt) - OW'(obi_rvalid_i);
      if (pending_q && !obi_gnt_i) begin
        stale_req_d     = 1'b1;
        redirect_addr_d = flush_addr_w;
      end else begin
        stale_req_d = 1'b0;
        req_addr_d  = flush_addr_w;
      end
    end
  end

  // NOTE: registers use <= so every flop updates from the same pre-edge values.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      req_addr_q      <= {boot_addr_i, 2'b00};
      resp_pc_q       <= {boot_addr_i, 2'b00};
      redirect_addr_q <= 32'h0;
      outstanding_q   <= '0;
      discard_q       <= '0;
      pending_q       <= 1'b0;
      stale_req_q     <= 1'b0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
    end else begin
      req_addr_q      <= req_addr_d;
      resp_pc_q       <= resp_pc_d;
      redirect_addr_q <= redirect_addr_d;
      outstanding_q   <= outstanding_d;
      discard_q       <= discard_d;
      pending_q       <= pending_d;
      stale_req_q     <= stale_req_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
    end
  end

  // NOTE: the storage array has no reset; the head outputs are masked by valid_o instead.
  always_ff @(posedge clk_i) begin
    if (push) begin
      instr_mem[wr_ptr_q] <= obi_rdata_i;
      pc_mem[wr_ptr_q]    <= resp_pc_q;
      err_mem[wr_ptr_q]   <= obi_err_i;
    end
  end

endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// Bench for instr_prefetch_buffer: behavioural OBI memory plus a scoreboard of the
// instruction stream the ID stage must see after each reset/flush.
module tb_instr_prefetch_buffer;

  localparam int DEPTH   = 4;
  localparam int MAX_OUT = 2;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic [29:0] boot_addr_i;
  logic        flush_i;
  logic [31:0] flush_addr_i;
  logic        obi_req_o, obi_gnt_i, obi_we_o, obi_rvalid_i, obi_rready_o, obi_err_i;
  logic [31:0] obi_addr_o, obi_wdata_o, obi_rdata_i;
  logic [3:0]  obi_be_o;
  logic        valid_o, err_o, ready_i;
  logic [31:0] instr_o, pc_o;

  always #5 clk_i = ~clk_i;

  instr_prefetch_buffer #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAX_OUT)) dut (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .boot_addr_i  (boot_addr_i),
    .flush_i      (flush_i),
    .flush_addr_i (flush_addr_i),
    .obi_req_o    (obi_req_o),
    .obi_gnt_i    (obi_gnt_i),
    .obi_addr_o   (obi_addr_o),
    .obi_we_o     (obi_we_o),
    .obi_be_o     (obi_be_o),
    .obi_wdata_o  (obi_wdata_o),
    .obi_rvalid_i (obi_rvalid_i),
    .obi_rready_o (obi_rready_o),
    .obi_rdata_i  (obi_rdata_i),
    .obi_err_i    (obi_err_i),
    .valid_o      (valid_o),
    .instr_o      (instr_o),
    .pc_o         (pc_o),
    .err_o        (err_o),
    .ready_i      (ready_i)
  );

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } txn_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        err;
  } exp_t;

  txn_t        resp_q[$];
  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          epoch = 0;
  int          lat = 1;
  int          pops = 0;
  int          r_epoch;
  logic [31:0] exp_req_addr, exp_resp_pc, err_addr, held_addr, flush_next_addr;
  int          held_epoch;
  bit          held = 0;
  bit          gnt_en = 1, rand_gnt = 0, ready_en = 1, rand_ready = 0, flush_next = 0;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // One bus cycle: drive memory/ID inputs, sample at +1, update the models, wait for the next negedge.
  task automatic tick();
    txn_t t;
    exp_t e;
    flush_i = flush_next;
    if (flush_next) flush_addr_i = flush_next_addr;
    flush_next   = 1'b0;
    obi_rvalid_i = 1'b0;
    obi_rdata_i  = 32'h0;
    obi_err_i    = 1'b0;
    r_epoch      = -1;
    if (resp_q.size() > 0 && resp_q[0].due <= cyc) begin
      t            = resp_q.pop_front();
      obi_rvalid_i = 1'b1;
      obi_rdata_i  = mem_data(t.addr);
      obi_err_i    = (t.addr == err_addr);
      r_epoch      = t.epoch;
    end
    obi_gnt_i = gnt_en & (rand_gnt ? 1'($urandom_range(0, 1)) : 1'b1);
    ready_i   = rand_ready ? 1'($urandom_range(0, 1)) : ready_en;
    #1;

    check("valid", 32'(valid_o), 32'(sb_q.size() != 0));
    if (valid_o && ready_i && !flush_i && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("pc", pc_o, e.pc);
      check("instr", instr_o, e.instr);
      check("err", 32'(err_o), 32'(e.err));
      pops++;
    end

    if (held) begin
      check("req_held", 32'(obi_req_o), 32'd1);
      check("addr_held", obi_addr_o, held_addr);
    end
    if (obi_req_o && obi_gnt_i) begin
      t.addr  = obi_addr_o;
      t.epoch = held ? held_epoch : epoch;
      t.due   = cyc + lat;
      if (t.epoch == epoch) begin
        check("req_addr", obi_addr_o, exp_req_addr);
        exp_req_addr = exp_req_addr + 32'd4;
      end
      resp_q.push_back(t);
      check("outstanding", 32'(resp_q.size() <= MAX_OUT), 32'd1);
      held = 1'b0;
    end else if (obi_req_o && !held) begin
      held       = 1'b1;
      held_epoch = epoch;
      held_addr  = obi_addr_o;
    end

    if (obi_rvalid_i && !flush_i && r_epoch == epoch) begin
      e.pc    = exp_resp_pc;
      e.instr = mem_data(exp_resp_pc);
      e.err   = (exp_resp_pc == err_addr);
      sb_q.push_back(e);
      exp_resp_pc = exp_resp_pc + 32'd4;
      check("fifo_bound", 32'(sb_q.size() <= DEPTH), 32'd1);
    end

    if (flush_i) begin
      sb_q.delete();
      epoch++;
      exp_req_addr = flush_addr_i & ~32'h3;
      exp_resp_pc  = flush_addr_i & ~32'h3;
    end

    @(negedge clk_i);
    cyc++;
  endtask

  task automatic do_flush(input logic [31:0] addr);
    flush_next      = 1'b1;
    flush_next_addr = addr;
    tick();
  endtask

  initial begin
    rst_n_i      = 1'b0;
    boot_addr_i  = 30'h0000_0020;
    flush_i      = 1'b0;
    flush_addr_i = 32'h0;
    obi_gnt_i    = 1'b0;
    obi_rvalid_i = 1'b0;
    obi_rdata_i  = 32'h0;
    obi_err_i    = 1'b0;
    ready_i      = 1'b0;
    err_addr     = 32'h1;
    exp_req_addr = 32'h80;
    exp_resp_pc  = 32'h80;

    repeat (3) @(negedge clk_i);
    check("rst_req", 32'(obi_req_o), 32'd0);
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_instr", instr_o, 32'h0);
    check("rst_pc", pc_o, 32'h0);
    check("rst_err", 32'(err_o), 32'd0);

    rst_n_i = 1'b1;
    #1;
    check("first_req", 32'(obi_req_o), 32'd1);
    check("first_addr", obi_addr_o, 32'h80);

    // Sequential fetch, one instruction per cycle once the pipe is full
    repeat (10) tick();
    pops = 0;
    repeat (12) tick();
    check("throughput", 32'(pops), 32'd12);

    // Backpressure: FIFO fills to DEPTH and requests stop
    ready_en = 1'b0;
    repeat (12) tick();
    check("fill_level", 32'(sb_q.size()), 32'(DEPTH));
    check("req_stall", 32'(obi_req_o), 32'd0);
    ready_en = 1'b1;
    repeat (12) tick();

    // Flush with two transactions in flight
    lat = 3;
    for (int i = 0; i < 20 && resp_q.size() != 2; i++) tick();
    check("two_in_flight", 32'(resp_q.size()), 32'd2);
    do_flush(32'h200);
    repeat (20) tick();
    lat = 1;
    repeat (5) tick();

    // Flush while a request waits for grant
    gnt_en = 1'b0;
    tick();
    check("pending_before_flush", 32'(held), 32'd1);
    do_flush(32'h300);
    tick();
    tick();
    gnt_en = 1'b1;
    repeat (15) tick();

    // Bus error at 0x84
    err_addr = 32'h84;
    do_flush(32'h80);
    repeat (12) tick();
    err_addr = 32'h1;

    // Address wrap, low flush bits ignored
    do_flush(32'hFFFF_FFFA);
    repeat (10) tick();

    // Random grant/ready/latency with occasional redirects
    rand_gnt   = 1'b1;
    rand_ready = 1'b1;
    for (int i = 0; i < 500; i++) begin
      lat = $urandom_range(1, 3);
      if ($urandom_range(0, 24) == 0) do_flush($urandom);
      else tick();
    end
    rand_gnt   = 1'b0;
    rand_ready = 1'b0;
    lat        = 1;
    repeat (20) tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
